grf: RTL and testbench
======================

# grf

Architectural general-purpose register file for the five-stage MIPS pipeline. It sits at the end of the W stage. Its write port takes the destination register number (`ma3`) and write-back data (`mWD`) produced by the W-stage write-back mux. Its two asynchronous read ports supply the D stage with rs/rt operands. An optional write-through bypass lets a D-stage read in the same cycle as a W-stage write see the new value.

## Interface
- `WIDTH`, 32, data width of each register.
- `clk` input 1: single system clock; all writes occur on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low; clears all registers.
- `we` input 1: write enable from the W-stage control decoder.
- `a3` input 5: write register number (W-stage `ma3`).
- `wd` input WIDTH: write data (W-stage `mWD`).
- `a1` input 5: read port 1 register number (D-stage `ir_D[25:21]`).
- `a2` input 5: read port 2 register number (D-stage `ir_D[20:16]`).
- `rd1` output WIDTH: read data for `a1`.
- `rd2` output WIDTH: read data for `a2`.

## Operation
- Storage is 32 entries × WIDTH bits, indexed 0..31.
- **Register $0**
  - $0 is hardwired to zero.
  - Writes to `a3 == 0` are discarded even when `we = 1`.
  - Reads of index 0 always return 0, including under bypass.
- **Write**
  - Occurs on the rising edge of `clk` when `we = 1`, `a3 != 0` and `rst_n = 1`.
  - Entry `a3` takes `wd`. No other entry changes.
- **Read**
  - Combinational: `rd1 = R[a1]` and `rd2 = R[a2]`, subject to the $0 rule and the bypass below.
- **Bypass** (only when `GRF_BYPASS_EN` is defined):
  - Condition: `we = 1`, `a3 != 0` and `a3 == a1`. Then `rd1 = wd` in the same cycle, before the edge.
  - Same rule for `rd2` with `a2`.
  - Both ports may bypass at once.
- **Simultaneous events**
  - `a1 == a2`: both ports return identical data.
  - A write and a read of the same index in one cycle: the read returns the old value (no bypass) or `wd` (bypass). After the edge, both builds return `wd`.
- **Reset**
  - Asserting `rst_n = 0` clears all 32 entries to 0 immediately, independent of `clk`.
  - While `rst_n = 0`, writes are ignored, and `rd1`/`rd2` read 0 for every address unless bypass is compiled in and a bypass hit applies.
  - Deassertion is taken synchronously by downstream logic. The first write accepted is on the first rising edge with `rst_n = 1`.
- **Invalid data**: there is no X or invalid-data state. Every entry holds a defined value from reset onward.

## Timing
- Write latency: 1 cycle. Data presented in cycle N is visible through the array from cycle N+1.
- Read latency: 0 cycles, combinational from `a1`/`a2`. With bypass, also combinational from `we`/`a3`/`wd`.
- Reset assertion to output: zero cycles, asynchronous. Reset values: all entries 0; `rd1 = rd2 = 0` for all addresses.
- Reset asserted in the same cycle as a write: the write is lost and the entry stays 0.
- No handshake. `we` is sampled only at the rising edge.

## Configuration
- `GRF_BYPASS_EN`
  - **Defined:** write-through bypass is active on both read ports as described under Operation. The hazard unit then needs no W→D forwarding path.
  - **Undefined:** reads return array contents only, and a same-cycle read of the register being written returns the old value. The hazard unit must then forward W-stage `mWD` to D.

## Test plan
- **Reset:** load R5 = 0x1234_5678 → assert `rst_n = 0` mid-cycle → `rd1` with `a1 = 5` is 0 before the next edge; R1..R31 all read 0.
- **Write/read:** `we = 1`, `a3 = 8`, `wd = 0xDEAD_BEEF` at edge N → from N+1, `a1 = 8` gives `rd1 = 0xDEAD_BEEF` and `a2 = 9` gives `rd2 = 0`.
- **$0 protection:** `we = 1`, `a3 = 0`, `wd = 0xFFFF_FFFF` → `rd1` with `a1 = 0` is 0 both before and after the edge, including in bypass builds.
- **Same-cycle bypass:** R3 = 0x11, then in one cycle `we = 1`, `a3 = 3`, `wd = 0x22`, `a1 = a2 = 3` → `rd1 = rd2 = 0x22` with `GRF_BYPASS_EN`, 0x11 without; both builds read 0x22 after the edge.
- **Write gating:** `we = 0`, `a3 = 7`, `wd = 0xAAAA_AAAA` over 3 edges → R7 unchanged at its prior value 0x5.
- **Reset vs. write:** `rst_n` falls in the same cycle as a write of 0x99 to R10 → after release, R10 reads 0.

Source files
------------

// File: rtl/grf.sv
// grf - architectural general-purpose register file (32 x WIDTH) for the
// five-stage MIPS pipeline. Written from the W stage, read by the D stage.
//
// Ports:
//   clk    : system clock, writes on rising edge
//   rst_n  : asynchronous active-low reset, clears every entry
//   we     : write enable
//   a3     : write register number
//   wd     : write data
//   a1, a2 : read register numbers
//   rd1    : combinational read data for a1
//   rd2    : combinational read data for a2
//
// Register $0 always reads as zero and ignores writes.
//
// Build option: define GRF_BYPASS_EN to forward wd onto a read port when
// the same-cycle write targets the register being read (write-through).
// Without it, reads return array contents only.

module grf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       a3,
    input  logic [WIDTH-1:0] wd,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs [32];
    logic             wr_valid;

    // $0 is never a legal write target
    assign wr_valid = we && (a3 != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[a3] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[a1];
        rd2 = regs[a2];
`ifdef GRF_BYPASS_EN
        if (wr_valid && (a3 == a1)) rd1 = wd;
        if (wr_valid && (a3 == a2)) rd2 = wd;
`endif
        // Applied last so $0 reads zero regardless of array or bypass
        if (a1 == 5'd0) rd1 = '0;
        if (a2 == 5'd0) rd2 = '0;
    end

endmodule

// File: tb/tb_grf.sv
// tb_grf - randomized, scoreboard-checked bench for grf.
// Stimulus computes expected read data from a behavioural model of the
// register file and queues it; a monitor on the falling clock edge pops
// and compares against rd1/rd2. Define GRF_BYPASS_EN for both the DUT and
// this bench to check the write-through build.

module tb_grf;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         we;
    logic [4:0]   a3;
    logic [W-1:0] wd;
    logic [4:0]   a1;
    logic [4:0]   a2;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;

    grf #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .a3    (a3),
        .wd    (wd),
        .a1    (a1),
        .a2    (a2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model [32];
    int           total = 0;
    int           bad   = 0;

    // Expected value on a read port given the current drive and model
    function automatic logic [W-1:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef GRF_BYPASS_EN
        if (we && a3 != 5'd0 && a3 == a) return wd;
`endif
        return model[a];
    endfunction

    // One cycle: commit the previous cycle's write to the model at the edge,
    // then drive new inputs and queue the expected read data.
    task automatic cyc(input logic r, input logic w, input logic [4:0] wa,
                       input logic [W-1:0] d, input logic [4:0] ra1,
                       input logic [4:0] ra2, input string nm);
        exp_t e;
        @(posedge clk);
        if (rst_n && we && a3 != 5'd0) model[a3] = wd;
        #1;
        rst_n = r;
        we    = w;
        a3    = wa;
        wd    = d;
        a1    = ra1;
        a2    = ra2;
        if (!r) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end
        e.name = nm;
        e.e1   = exp_rd(ra1);
        e.e2   = exp_rd(ra2);
        sb.push_back(e);
    endtask

    // Monitor: compare at the falling edge, away from the write edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (rd1 !== e.e1) begin
                    bad++;
                    $display("FAIL %s rd1 a1=%0d got=%h exp=%h", e.name, a1, rd1, e.e1);
                end
                total++;
                if (rd2 !== e.e2) begin
                    bad++;
                    $display("FAIL %s rd2 a2=%0d got=%h exp=%h", e.name, a2, rd2, e.e2);
                end
            end
        end
    end

    initial begin
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] wa;
        rst_n = 1'b0;
        we    = 1'b0;
        a3    = '0;
        wd    = '0;
        a1    = '0;
        a2    = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        cyc(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd5, "reset_state");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd1, 5'd31, "after_release");

        // Mid-cycle asynchronous reset clears a loaded entry
        cyc(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd4, "load_r5");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd5, "read_r5");
        cyc(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5, "async_reset");
        for (int i = 1; i < 32; i += 2) begin
            ra = 5'(i);
            rb = 5'((i + 1) % 32);
            cyc(1'b1, 1'b0, 5'd0, '0, ra, rb, "reset_scan");
        end

        // Basic write then read
        cyc(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd9, "write_r8");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd8, 5'd9, "read_r8");

        // $0 protection, before and after the edge
        cyc(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "r0_write");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, "r0_after");

        // Same-cycle read of the register being written
        cyc(1'b1, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0, "load_r3");
        cyc(1'b1, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3, "same_cycle");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd3, 5'd3, "after_same_cycle");

        // Write gating: we=0 leaves R7 alone
        cyc(1'b1, 1'b1, 5'd7, 32'h5, 5'd0, 5'd0, "load_r7");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd7, "we_gate");
        end
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd8, "we_gate_after");

        // Reset in the same cycle as a write: the write is lost
        cyc(1'b0, 1'b1, 5'd10, 32'h99, 5'd10, 5'd9, "reset_vs_write");
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd10, 5'd10, "reset_vs_write_after");

        // Randomized traffic, read addresses often aimed at the write target
        for (int i = 0; i < 400; i++) begin
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), wa,
                $urandom(), ra, rb, "random");
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
